// File: rtl/stoch_decode.sv
// Stochastic-to-binary decoder: counts ones over 2^WINDOW_LOG2 valid samples per start request.
// Optional signed dual-rail mode selected by defining STOCH_DECODE_SIGNED_EN (adds the x_m input).
module stoch_decode #(
  parameter int unsigned WINDOW_LOG2 = 8,
`ifdef STOCH_DECODE_SIGNED_EN
  localparam int unsigned OUT_W = WINDOW_LOG2 + 2
`else
  localparam int unsigned OUT_W = WINDOW_LOG2 + 1
`endif
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic             in_valid,
  input  logic             x,
`ifdef STOCH_DECODE_SIGNED_EN
  input  logic             x_m,
`endif
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] value
);

  localparam int unsigned CNT_W = WINDOW_LOG2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] inc_c;
  logic [OUT_W-1:0] sum_c;
  logic             last_c;

  // Per-sample contribution; the signed -1 is all-ones so a plain add gives two's complement.
  always_comb begin
    inc_c = '0;
`ifdef STOCH_DECODE_SIGNED_EN
    if (x && !x_m)
      inc_c = OUT_W'(1);
    else if (!x && x_m)
      inc_c = '1;
`else
    inc_c = OUT_W'(x);
`endif
  end

  assign sum_c  = acc + inc_c;
  assign last_c = (cnt == '1);

  // Window controller; busy/out_valid are registered alongside the state so they never overlap.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      value     <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= sum_c;
            cnt <= cnt + CNT_W'(1);
            if (last_c) begin
              value     <= sum_c;
              busy      <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              // Back-to-back window: restart counting on the handshake cycle itself.
              acc   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= ACCUM;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stoch_decode.sv
// Self-checking bench for stoch_decode at WINDOW_LOG2=4: vector table, corner sequences, random windows.
module tb_stoch_decode;

  localparam int unsigned N  = 4;
  localparam int unsigned NS = 16;
`ifdef STOCH_DECODE_SIGNED_EN
  localparam int unsigned OUT_W = N + 2;
`else
  localparam int unsigned OUT_W = N + 1;
`endif

  logic             CLK = 1'b0;
  logic             nRST;
  logic             start;
  logic             in_valid;
  logic             x;
`ifdef STOCH_DECODE_SIGNED_EN
  logic             x_m;
`endif
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] value;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  stoch_decode #(.WINDOW_LOG2(N)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .start(start),
    .in_valid(in_valid),
    .x(x),
`ifdef STOCH_DECODE_SIGNED_EN
    .x_m(x_m),
`endif
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .value(value)
  );

  typedef struct {
    string       name;
    logic [15:0] xp;
    logic [15:0] xm;
    int          nstall;
    int          exp_val;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int value_i();
`ifdef STOCH_DECODE_SIGNED_EN
    return int'($signed(value));
`else
    return int'(value);
`endif
  endfunction

  // Reference: the decoded count is just the population of contributing samples.
  function automatic int model(input logic [15:0] xp, input logic [15:0] xm);
`ifdef STOCH_DECODE_SIGNED_EN
    return $countones(xp & ~xm) - $countones(~xp & xm);
`else
    if (xm === 16'hxxxx) return -1;
    return $countones(xp);
`endif
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_bits(input logic bp, input logic bm);
    x = bp;
`ifdef STOCH_DECODE_SIGNED_EN
    x_m = bm;
`else
    if (bm === 1'bz) x = 1'b0;
`endif
  endtask

  // One full window; start cycle carries a valid 1 that must not be counted.
  task automatic run_window(input string name, input logic [15:0] xp, input logic [15:0] xm,
                            input int nstall, input int exp_val, input int exp_lat, input bit ack);
    int cyc;
    int first;
    int i;
    int stalls_left;
    start = 1'b1; in_valid = 1'b1; set_bits(1'b1, 1'b0); out_ready = 1'b0;
    step();
    start = 1'b0;
    cyc = 1;
    first = out_valid ? cyc : -1;
    i = 0;
    stalls_left = nstall;
    while (i < NS) begin
      if (stalls_left > 0 && ($urandom_range(0, 1) == 1 || stalls_left >= NS - i)) begin
        in_valid = 1'b0;
        set_bits(1'b1, 1'($urandom_range(0, 1)));
        stalls_left--;
      end else begin
        in_valid = 1'b1;
        set_bits(xp[i], xm[i]);
        i++;
      end
      step();
      cyc++;
      if (out_valid && first < 0) first = cyc;
    end
    in_valid = 1'b0;
    for (int w = 0; w < 8 && first < 0; w++) begin
      step();
      cyc++;
      if (out_valid) first = cyc;
    end
    check({name, "_latency"}, first, exp_lat);
    check({name, "_value"}, value_i(), exp_val);
    check({name, "_busy_done"}, int'(busy), 0);
    if (ack) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({name, "_ack_valid"}, int'(out_valid), 0);
      check({name, "_ack_busy"}, int'(busy), 0);
    end
  endtask

  // busy and out_valid must be mutually exclusive at all times.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      checks++;
      if (busy && out_valid) begin
        failures++;
        $display("FAIL excl busy=%0b out_valid=%0b required not both 1", busy, out_valid);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rp;
    logic [15:0] rm;
    int          rs;

    nRST = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; set_bits(1'b0, 1'b0);
    step(); step();
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_value", value_i(), 0);
    nRST = 1'b1;
    step();

    tbl.push_back('{"all_ones",   16'hFFFF, 16'h0000, 0, 16, 17});
    tbl.push_back('{"alternate",  16'h5555, 16'h0000, 0,  8, 17});
    tbl.push_back('{"all_zeros",  16'h0000, 16'h0000, 0,  0, 17});
    tbl.push_back('{"stall5",     16'hFFFF, 16'h0000, 5, 16, 22});
    tbl.push_back('{"low_half",   16'h00FF, 16'h0000, 2,  8, 19});
`ifdef STOCH_DECODE_SIGNED_EN
    tbl.push_back('{"sgn_12p_4m", 16'h0FFF, 16'hF000, 0,   8, 17});
    tbl.push_back('{"sgn_both",   16'hFFFF, 16'hFFFF, 0,   0, 17});
    tbl.push_back('{"sgn_all_m",  16'h0000, 16'hFFFF, 0, -16, 17});
`endif
    foreach (tbl[k])
      run_window(tbl[k].name, tbl[k].xp, tbl[k].xm, tbl[k].nstall, tbl[k].exp_val, tbl[k].exp_lat, 1'b1);

    // Hold a result with out_ready low; a start mid-hold must be ignored.
    run_window("hold", 16'hFFFF, 16'h0000, 0, 16, 17, 1'b0);
    for (int c = 0; c < 10; c++) begin
      start = (c == 5);
      step();
      check("hold_valid", int'(out_valid), 1);
      check("hold_value", value_i(), 16);
      check("hold_busy", int'(busy), 0);
    end
    out_ready = 1'b1; start = 1'b1;
    step();
    out_ready = 1'b0; start = 1'b0;
    check("b2b_busy", int'(busy), 1);
    check("b2b_valid", int'(out_valid), 0);
    for (int i = 0; i < NS; i++) begin
      in_valid = 1'b1;
      set_bits(logic'(i < 4), 1'b0);
      step();
    end
    in_valid = 1'b0;
    check("b2b_done", int'(out_valid), 1);
    check("b2b_value", value_i(), 4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-window must wipe everything, including the previous result.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; set_bits(1'b1, 1'b0);
      step();
    end
    nRST = 1'b0;
    step();
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_value", value_i(), 0);
    step();
    nRST = 1'b1; in_valid = 1'b0;
    step();
    check("postrst_busy", int'(busy), 0);
    run_window("postrst", 16'h0000, 16'h0000, 0, 0, 17, 1'b1);

    // Random windows against the population-count model.
    for (int r = 0; r < 10; r++) begin
      rp = 16'($urandom);
      rm = 16'($urandom);
`ifndef STOCH_DECODE_SIGNED_EN
      rm = 16'h0000;
`endif
      rs = $urandom_range(0, 4);
      run_window($sformatf("rand%0d", r), rp, rm, rs, model(rp, rm), 17 + rs, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stoch_decode.md
Name: stoch_decode

Overview:
- Decodes a stochastic bitstream back to a binary estimate: counts ones over a fixed window of 2^WINDOW_LOG2 valid samples.
- Presents the count on a valid/ready output interface.
- Sits at the output end of stochastic datapaths such as dot-product and adder units, where results return to binary logic.
- Converts one window per start request; windows may run back-to-back.

Parameters:
- WINDOW_LOG2, 8, log2 of samples per window (N); window length 2^N valid cycles.
- OUT_W (localparam): N+1 unsigned; N+2 two's complement when STOCH_DECODE_SIGNED_EN is defined.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- nRST  input  1  reset; synchronous, active-low.
- start  input  1  request a new window; honoured only in IDLE or on the DONE handshake cycle.
- in_valid  input  1  qualifies x (and x_m) this cycle; low = stall.
- x  input  1  stochastic bit (positive channel when signed).
- x_m  input  1  negative-channel bit; present only with STOCH_DECODE_SIGNED_EN.
- busy  output  1  high in ACCUM.
- out_valid  output  1  high in DONE.
- out_ready  input  1  consumer accepts value.
- value  output  OUT_W  decoded count; estimate = value / 2^N.

Behaviour:
- Reset (nRST=0 at a clock edge):
  - state to IDLE; busy=0, out_valid=0, value=0; accumulator and sample counter cleared.
  - Overrides everything, including mid-window or a pending output.
- IDLE:
  - start=1 -> clear accumulator and sample counter; go to ACCUM.
  - Bits present in the start cycle are not counted.
- ACCUM:
  - Each cycle with in_valid=1: accumulator += x; sample counter += 1.
  - in_valid=0: hold both.
  - start is ignored.
  - On the valid sample where the sample counter equals 2^N-1, value <= accumulator + current bit and go to DONE.
  - The sample counter is N bits and is allowed to wrap.
  - The accumulator is OUT_W bits so the full count 2^N never overflows.
- DONE:
  - out_valid=1; value held stable until handshake.
  - x and in_valid are ignored.
  - out_valid & out_ready & !start -> IDLE.
  - out_valid & out_ready & start -> ACCUM with cleared counters (back-to-back, no bubble).
  - start without out_ready is ignored.
- Latency:
  - Start sampled at edge k, in_valid held high: samples taken at edges k+1..k+2^N.
  - out_valid visible from edge k+2^N onward, i.e. 2^N+1 cycles after start.
  - Each stall cycle adds 1 cycle.
- value stays at its last decoded result in IDLE/ACCUM; it is updated only on entry to DONE.
- busy and out_valid are never both high.

Optional Feature:
- Macro: STOCH_DECODE_SIGNED_EN.
- Defined:
  - x_m port exists; value is OUT_W=N+2 two's complement.
  - Per valid sample: +1 if x=1 & x_m=0; -1 if x=0 & x_m=1; 0 otherwise.
  - Range [-2^N, +2^N].
  - The accumulator is signed; the final-sample add uses the same rule.
- Not defined:
  - No x_m port; value is unsigned N+1 bits.
  - Per sample +x.

Test Plan:
1. N=4, start pulse, in_valid=1, x=1 for 16 cycles -> out_valid 17 cycles after start, value=16, busy low in the same cycle.
2. N=4, x alternating 1,0 for 16 valid cycles -> value=8; x=0 throughout -> value=0.
3. N=4, 16 valid samples of x=1 interleaved with 5 in_valid=0 cycles carrying x=1 -> value=16, out_valid 22 cycles after start; stalled bits not counted.
4. out_ready low for 10 cycles after out_valid, with start pulsed mid-hold -> value/out_valid held, start ignored. Then out_ready=1 with start=1 -> next cycle busy=1, second window (x=1 for 4 samples) -> value=4.
5. nRST=0 after 7 valid samples of x=1, then released; new start with x=0 for 16 samples -> all outputs 0 during reset, result value=0 (no residue).
6. STOCH_DECODE_SIGNED_EN, N=4: 12 samples (x=1, x_m=0), 4 samples (x=0, x_m=1) -> value=8. 16 samples (x=1, x_m=1) -> value=0. 16 samples (x=0, x_m=1) -> value=-16 (6'b110000).
